// File: rtl/vscale_htif_pcr_responder.sv
// vscale_htif_pcr_responder: HTIF PCR endpoint owning tohost/fromhost, one response per host request
module vscale_htif_pcr_responder #(
  parameter int HTIF_PCR_WIDTH = 64,
  parameter int XLEN = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      htif_pcr_req_valid,
  output logic                      htif_pcr_req_ready,
  input  logic                      htif_pcr_req_rw,
  input  logic [11:0]               htif_pcr_req_addr,
  input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
  output logic                      htif_pcr_resp_valid,
  input  logic                      htif_pcr_resp_ready,
  output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data,
  input  logic                      core_tohost_wen,
  input  logic [XLEN-1:0]           core_tohost_wdata,
  input  logic                      core_fromhost_wen,
  input  logic [XLEN-1:0]           core_fromhost_wdata,
  output logic [XLEN-1:0]           tohost,
  output logic [XLEN-1:0]           fromhost,
  output logic                      fromhost_pending
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_next;
  logic accept, hit_to, hit_from, host_wr_to, host_wr_from;
  logic [XLEN-1:0] old;
  logic unused_req_bits;
  assign unused_req_bits = ^htif_pcr_req_data;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_next;
  // ready is masked by reset so the host sees no accept window while reset is held
  always_comb begin
    htif_pcr_req_ready = (state == IDLE) && !reset;
    htif_pcr_resp_valid = state == RESP;
    accept = htif_pcr_req_valid && htif_pcr_req_ready;
    state_next = (state == IDLE) ? (accept ? RESP : IDLE) : (htif_pcr_resp_ready ? IDLE : RESP);
  end
  assign hit_to = htif_pcr_req_addr == 12'h780;
  assign hit_from = htif_pcr_req_addr == 12'h781;
  assign old = hit_to ? tohost : hit_from ? fromhost : '0;
  assign host_wr_to = accept && htif_pcr_req_rw && hit_to;
  assign host_wr_from = accept && htif_pcr_req_rw && hit_from;
  assign fromhost_pending = fromhost != '0;
  // core writes take priority over a same-edge host write to the same register
  always_ff @(posedge clk) begin
    if (reset) begin
      tohost <= '0;
      fromhost <= '0;
      htif_pcr_resp_data <= '0;
    end else begin
      tohost <= core_tohost_wen ? core_tohost_wdata : host_wr_to ? htif_pcr_req_data[XLEN-1:0] : tohost;
      fromhost <= core_fromhost_wen ? core_fromhost_wdata : host_wr_from ? htif_pcr_req_data[XLEN-1:0] : fromhost;
      if (accept) htif_pcr_resp_data <= HTIF_PCR_WIDTH'(old);
    end
  end
endmodule

// File: tb/tb_vscale_htif_pcr_responder.sv
// tb_vscale_htif_pcr_responder: randomized self-checking bench with a register-map reference model
module tb_vscale_htif_pcr_responder;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_ready, req_rw = 0;
  logic [11:0] req_addr = 0;
  logic [63:0] req_data = 0;
  logic resp_valid, resp_ready = 0;
  logic [63:0] resp_data;
  logic to_wen = 0, from_wen = 0;
  logic [31:0] to_wdata = 0, from_wdata = 0;
  logic [31:0] tohost, fromhost;
  logic pending;
  int total = 0, bad = 0;
  logic [31:0] to_m = 0, from_m = 0;

  vscale_htif_pcr_responder dut (
    .clk(clk), .reset(reset),
    .htif_pcr_req_valid(req_valid), .htif_pcr_req_ready(req_ready),
    .htif_pcr_req_rw(req_rw), .htif_pcr_req_addr(req_addr), .htif_pcr_req_data(req_data),
    .htif_pcr_resp_valid(resp_valid), .htif_pcr_resp_ready(resp_ready), .htif_pcr_resp_data(resp_data),
    .core_tohost_wen(to_wen), .core_tohost_wdata(to_wdata),
    .core_fromhost_wen(from_wen), .core_fromhost_wdata(from_wdata),
    .tohost(tohost), .fromhost(fromhost), .fromhost_pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_read(input logic [11:0] a);
    return a == 12'h780 ? {32'h0, to_m} : a == 12'h781 ? {32'h0, from_m} : 64'h0;
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [63:0] d);
    if (a == 12'h780) to_m = d[31:0];
    else if (a == 12'h781) from_m = d[31:0];
  endtask

  task automatic core_wr(input bit to_reg, input logic [31:0] v);
    if (to_reg) begin to_wen = 1; to_wdata = v; to_m = v; end
    else begin from_wen = 1; from_wdata = v; from_m = v; end
    tick();
    to_wen = 0;
    from_wen = 0;
  endtask

  task automatic host(input bit rw, input logic [11:0] a, input logic [63:0] d, input int hold,
                      output logic [63:0] r);
    int n = 0;
    req_valid = 1; req_rw = rw; req_addr = a; req_data = d; resp_ready = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL req_ready_timeout: ready=%b wanted 1", req_ready); end
    tick();
    req_valid = 0;
    r = resp_data;
    repeat (hold) tick();
    resp_ready = 1;
    tick();
    resp_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    total++; if (resp_data !== 64'h0) begin bad++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
    total++; if ({tohost, fromhost, pending} !== 65'h0) begin bad++; $display("FAIL rst_regs: got %h %h %b want 0", tohost, fromhost, pending); end
    reset = 0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_polling();
    logic [63:0] r;
    req_valid = 1; req_rw = 0; req_addr = 12'h780; resp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (resp_valid !== (i % 2 == 0) || (resp_valid && resp_data !== model_read(12'h780))) begin
        bad++; $display("FAIL poll_%0d: valid=%b data=%h want valid=%b data=%h", i, resp_valid, resp_data, i % 2 == 0, model_read(12'h780));
      end
    end
    req_valid = 0; resp_ready = 0;
    core_wr(1, 32'h1);
    total++; if (tohost !== 32'h1) begin bad++; $display("FAIL core_tohost_visible: got %h want 1", tohost); end
    host(0, 12'h780, 64'h0, 0, r);
    total++; if (r !== 64'h1) begin bad++; $display("FAIL poll_after_core: got %h want 1", r); end
  endtask

  task automatic test_tohost_clear();
    logic [63:0] r;
    core_wr(1, 32'h15);
    host(0, 12'h780, 64'h0, 0, r);
    total++; if (r !== 64'h15 || (r >> 1) !== 64'd10) begin bad++; $display("FAIL tohost_read: got %h want 15", r); end
    host(1, 12'h780, 64'h0, 1, r);
    total++; if (r !== 64'h15) begin bad++; $display("FAIL tohost_clear_resp: got %h want 15", r); end
    model_write(12'h780, 64'h0);
    host(0, 12'h780, 64'h0, 0, r);
    total++; if (r !== 64'h0) begin bad++; $display("FAIL tohost_after_clear: got %h want 0", r); end
  endtask

  task automatic test_fromhost();
    logic [63:0] r;
    host(1, 12'h781, 64'hFFFF_FFFF_0000_00AB, 0, r);
    total++; if (r !== 64'h0) begin bad++; $display("FAIL fromhost_wr_resp: got %h want 0", r); end
    model_write(12'h781, 64'hFFFF_FFFF_0000_00AB);
    total++; if (fromhost !== 32'hAB || pending !== 1'b1) begin bad++; $display("FAIL fromhost_val: got %h pend=%b want ab pend=1", fromhost, pending); end
    core_wr(0, 32'h0);
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL fromhost_pending_clear: got %b want 0", pending); end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp;
    core_wr(1, $urandom | 32'h1);
    exp = model_read(12'h780);
    req_valid = 1; req_rw = 0; req_addr = 12'h780; resp_ready = 0;
    tick();
    req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (resp_valid !== 1'b1 || resp_data !== exp || req_ready !== 1'b0) begin
        bad++; $display("FAIL hold_%0d: valid=%b data=%h ready=%b want 1 %h 0", i, resp_valid, resp_data, req_ready, exp);
      end
      tick();
    end
    resp_ready = 1;
    tick();
    resp_ready = 0;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL hold_release: valid=%b ready=%b want 0 1", resp_valid, req_ready); end
  endtask

  task automatic test_collision();
    logic [63:0] exp;
    core_wr(1, 32'h3);
    exp = model_read(12'h780);
    req_valid = 1; req_rw = 1; req_addr = 12'h780; req_data = 64'h7;
    to_wen = 1; to_wdata = 32'h9; resp_ready = 0;
    tick();
    req_valid = 0; to_wen = 0;
    to_m = 32'h9;
    total++; if (tohost !== 32'h9) begin bad++; $display("FAIL collide_tohost: got %h want 9", tohost); end
    total++; if (resp_data !== exp) begin bad++; $display("FAIL collide_resp: got %h want %h", resp_data, exp); end
    resp_ready = 1;
    tick();
    resp_ready = 0;
  endtask

  task automatic test_unmapped();
    logic [63:0] r;
    core_wr(0, 32'h5A);
    host(1, 12'h123, {$urandom, $urandom}, 0, r);
    total++; if (r !== 64'h0) begin bad++; $display("FAIL unmapped_wr_resp: got %h want 0", r); end
    total++; if (tohost !== to_m || fromhost !== from_m) begin bad++; $display("FAIL unmapped_regs: got %h %h want %h %h", tohost, fromhost, to_m, from_m); end
    host(0, 12'h123, 64'h0, 0, r);
    total++; if (r !== 64'h0) begin bad++; $display("FAIL unmapped_rd_resp: got %h want 0", r); end
  endtask

  task automatic test_reset_mid();
    core_wr(1, 32'hDEAD);
    req_valid = 1; req_rw = 0; req_addr = 12'h780; resp_ready = 0;
    tick();
    req_valid = 0;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", resp_valid); end
    reset = 1;
    tick();
    to_m = 0; from_m = 0;
    total++;
    if (resp_valid !== 1'b0 || tohost !== 32'h0 || fromhost !== 32'h0 || resp_data !== 64'h0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset: valid=%b to=%h from=%h data=%h ready=%b want all 0", resp_valid, tohost, fromhost, resp_data, req_ready);
    end
    reset = 0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_random();
    logic [63:0] r, exp, d;
    logic [11:0] a;
    bit rw;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: core_wr(1, $urandom);
        1: core_wr(0, $urandom_range(0, 1) ? 32'h0 : $urandom);
        default: begin
          a = $urandom_range(0, 2) == 0 ? 12'h780 : $urandom_range(0, 1) ? 12'h781 : 12'($urandom);
          rw = $urandom_range(0, 1);
          d = {$urandom, $urandom};
          exp = model_read(a);
          host(rw, a, d, $urandom_range(0, 3), r);
          if (rw) model_write(a, d);
          total++; if (r !== exp) begin bad++; $display("FAIL rand_resp_%0d: addr=%h got %h want %h", i, a, r, exp); end
        end
      endcase
      total++;
      if (tohost !== to_m || fromhost !== from_m || pending !== (from_m != 0)) begin
        bad++; $display("FAIL rand_regs_%0d: got %h %h %b want %h %h %b", i, tohost, fromhost, pending, to_m, from_m, from_m != 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_polling();
    test_tohost_clear();
    test_fromhost();
    test_backpressure();
    test_collision();
    test_unmapped();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vscale_htif_pcr_responder.md
# vscale_htif_pcr_responder

Core-side endpoint of the HTIF PCR protocol. It accepts host read/write requests on the `htif_pcr_req_*` channel and returns one response per request on the `htif_pcr_resp_*` channel. It owns the `tohost` and `fromhost` registers shared between the host and the CSR file. It sits inside `vscale_top` between the HTIF pins and the CSR file, and is the responder for the host-side tohost polling loop used by the hex test harness.

## Interface
- `HTIF_PCR_WIDTH`, default 64: host data width (matches `` `HTIF_PCR_WIDTH``).
- `XLEN`, default 32: core register width; must be ≤ `HTIF_PCR_WIDTH`.
- `clk` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `htif_pcr_req_valid` in 1: host request valid.
- `htif_pcr_req_ready` out 1: responder can accept a request.
- `htif_pcr_req_rw` in 1: 1 = write, 0 = read.
- `htif_pcr_req_addr` in 12: CSR address.
- `htif_pcr_req_data` in `HTIF_PCR_WIDTH`: write data.
- `htif_pcr_resp_valid` out 1: response valid.
- `htif_pcr_resp_ready` in 1: host accepts response.
- `htif_pcr_resp_data` out `HTIF_PCR_WIDTH`: response data.
- `core_tohost_wen` in 1: CSR file writes `tohost`.
- `core_tohost_wdata` in `XLEN`: core `tohost` write data.
- `core_fromhost_wen` in 1: CSR file writes `fromhost`.
- `core_fromhost_wdata` in `XLEN`: core `fromhost` write data.
- `tohost` out `XLEN`: current `tohost` register.
- `fromhost` out `XLEN`: current `fromhost` register.
- `fromhost_pending` out 1: `fromhost` is non-zero (host message waiting).

## Operation
- Two-state FSM:
  - IDLE: `htif_pcr_req_ready` = 1.
  - RESP: `htif_pcr_resp_valid` = 1.
- IDLE→RESP on accept (`req_valid && req_ready`). RESP→IDLE on `resp_valid && resp_ready`.
- Decoded addresses:
  - `` `CSR_ADDR_TO_HOST`` (0x780) → `tohost`.
  - `` `CSR_ADDR_FROM_HOST`` (0x781) → `fromhost`.
  - Any other address: read returns 0; write has no effect. No error signalling.
- On accept, the response register captures the pre-update value of the addressed register, zero-extended from `XLEN` to `HTIF_PCR_WIDTH`. This applies to both reads and writes (write returns the old value).
- A host write stores `req_data[XLEN-1:0]` into the addressed register at the accept edge; upper bits are discarded.
- Reads are non-destructive. The host clears `tohost` by writing 0.
- Core writes take effect every cycle they are asserted, in any FSM state.
- Same-edge collision on the same register: the core write wins over the host write. The response still carries the pre-edge value.
- `fromhost_pending` = (`fromhost` != 0), combinational from the register.
- Response data is held stable while `resp_valid` && !`resp_ready`.

## Timing
- Reset values:
  - FSM = IDLE.
  - `tohost` = 0, `fromhost` = 0.
  - `htif_pcr_resp_data` = 0.
  - `htif_pcr_resp_valid` = 0, `fromhost_pending` = 0.
  - `htif_pcr_req_ready` = 0 while `reset` is high, 1 in the first cycle after reset deasserts.
- Latency: request accepted at edge N → `resp_valid` high in cycle N+1 (registered, no combinational req→resp path).
- Throughput: at most one request per 2 cycles. `req_ready` returns high the cycle after the response handshake. The response handshake and a new accept never occur on the same edge.
- `htif_pcr_req_ready` depends only on FSM state, never on `req_valid`.
- Reset mid-transaction: a pending response is dropped and `resp_valid` goes low in the cycle after the reset edge. Register contents are cleared.
- Core writes to `tohost` are visible on the `tohost` output in the cycle after `core_tohost_wen`. A host read accepted in that cycle returns the new value.

## Test plan
- Reset, then `req_valid`=1, read 0x780, `resp_ready`=1 held → `resp_valid` pulses every 2nd cycle with data 0. After `core_tohost_wen` with data 1, the next response = 0x1.
- Core writes `tohost` = 0x15 → host read returns 0x15 (value>>1 = 10). Host write 0 to 0x780 → that write's response = 0x15; subsequent read returns 0.
- Host writes 0xFFFF_FFFF_0000_00AB to 0x781 → `fromhost` = 0xAB, `fromhost_pending` = 1. Core writes 0 → pending = 0 the next cycle.
- Hold `resp_ready`=0 for 5 cycles after a read → `resp_valid` and data stay stable, `req_ready` = 0. Release → handshake, then `req_ready` = 1 in the following cycle.
- Same-edge host write 0x7 and core write 0x9 to `tohost` → `tohost` = 0x9; response = old value.
- Read/write 0x123 → read response 0, write leaves `tohost`/`fromhost` unchanged. Assert `reset` while `resp_valid` = 1 → `resp_valid` = 0 and all registers = 0 after the edge.
